note_slot_scheduler: RTL and testbench

//  Owns the pool of falling note blocks for the 4-lane perspective track. Accepts spawn requests.

---
 rtl/beat_pkg.sv | 16 +
 rtl/note_slot_table.sv | 49 ++++
 rtl/note_slot_scheduler.sv | 165 ++++++++++++++++
 tb/tb_note_slot_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// Shared types and screen constants for the 4-lane beat track.
package beat_pkg;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;

  typedef logic [2:0] lane_t;

  typedef struct packed {
    logic       valid;
    lane_t      lane;
    logic [9:0] y;
    logic [9:0] x;
    logic [9:0] width;
  } slot_t;
endpackage

// File: rtl/note_slot_table.sv
// Note slot register file: one write port, registered draw read, combinational
// update read and lowest-free-slot priority encoder.
module note_slot_table
  import beat_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_idx,
  input  slot_t                        wr_data,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_idx,
  output slot_t                        rd_data,
  input  logic [$clog2(NUM_SLOTS)-1:0] upd_idx,
  output slot_t                        upd_data,
  output logic                         free_any,
  output logic [$clog2(NUM_SLOTS)-1:0] free_idx
);
  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

  slot_t r_slots [NUM_SLOTS];
  slot_t r_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
      r_rd <= '0;
    end else begin
      // Readout samples the array before this edge's write lands.
      r_rd <= r_slots[rd_idx];
      if (wr_en) r_slots[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!r_slots[i].valid && !free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign rd_data  = r_rd;
  assign upd_data = r_slots[upd_idx];
endmodule

// File: rtl/note_slot_scheduler.sv
// Falling-note pool: spawns notes, advances them once per frame and retires
// them past the bottom row, sharing one lane-geometry lookup between both paths.
module note_slot_scheduler
  import beat_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SPEED     = 2,
  parameter logic [9:0]  Y_SPAWN   = 10'd0,
  parameter logic [9:0]  Y_BOTTOM  = 10'd479
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_tick,
  input  logic                         spawn_valid,
  input  logic [2:0]                   spawn_lane,
  output logic                         spawn_ready,
  output logic [2:0]                   lk_block_position,
  output logic [9:0]                   lk_y_position,
  input  logic [9:0]                   lk_x_position,
  input  logic [9:0]                   lk_block_width,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_slot,
  output logic                         rd_valid,
  output logic [2:0]                   rd_lane,
  output logic [9:0]                   rd_y,
  output logic [9:0]                   rd_x,
  output logic [9:0]                   rd_width,
  output logic                         busy,
  output logic                         retire_pulse,
  output logic [2:0]                   retire_lane,
  output logic [7:0]                   overrun_count
);
  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_pending;
  logic [7:0]       r_overrun;
  logic             r_retire_pulse;
  lane_t            r_retire_lane;

  slot_t            w_cur, w_rd, w_wr_data;
  logic             w_we, w_free_any, w_pass_start, w_spawn_go, w_off_screen;
  logic [IDX_W-1:0] w_wr_idx, w_free_idx;
  logic [10:0]      w_y_new;

  note_slot_table #(.NUM_SLOTS(NUM_SLOTS)) u_table (
    .clk      (Clk),
    .rst      (Reset),
    .wr_en    (w_we),
    .wr_idx   (w_wr_idx),
    .wr_data  (w_wr_data),
    .rd_idx   (rd_slot),
    .rd_data  (w_rd),
    .upd_idx  (r_idx),
    .upd_data (w_cur),
    .free_any (w_free_any),
    .free_idx (w_free_idx)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_pass_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_tick || r_pending) begin
          w_pass_start = 1'b1;
          w_state_nxt  = S_UPDATE;
          w_idx_nxt    = '0;
        end
      end
      S_UPDATE: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One pending tick is remembered; each further tick before the pass starts is lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pending <= 1'b0;
      r_overrun <= '0;
    end else if (w_pass_start) begin
      r_pending <= 1'b0;
      if (frame_tick && r_pending && r_overrun != 8'hFF) r_overrun <= r_overrun + 1'b1;
    end else if (r_state == S_UPDATE && frame_tick) begin
      if (!r_pending)              r_pending <= 1'b1;
      else if (r_overrun != 8'hFF) r_overrun <= r_overrun + 1'b1;
    end
  end

  assign spawn_ready  = (r_state == S_IDLE) && w_free_any;
  assign w_spawn_go   = spawn_valid && spawn_ready;
  assign w_y_new      = {1'b0, w_cur.y} + 11'(SPEED);
  assign w_off_screen = w_y_new > {1'b0, Y_BOTTOM};

  always_comb begin
    lk_block_position = spawn_lane;
    lk_y_position     = Y_SPAWN;
    w_we              = 1'b0;
    w_wr_idx          = w_free_idx;
    w_wr_data         = w_cur;
    if (r_state == S_UPDATE) begin
      lk_block_position = w_cur.lane;
      lk_y_position     = w_y_new[9:0];
      if (w_cur.valid) begin
        w_we     = 1'b1;
        w_wr_idx = r_idx;
        if (w_off_screen) begin
          w_wr_data.valid = 1'b0;
        end else begin
          w_wr_data.y     = w_y_new[9:0];
          w_wr_data.x     = lk_x_position;
          w_wr_data.width = lk_block_width;
        end
      end
    end else if (w_spawn_go) begin
      w_we            = 1'b1;
      w_wr_data.valid = 1'b1;
      w_wr_data.lane  = spawn_lane;
      w_wr_data.y     = Y_SPAWN;
      w_wr_data.x     = lk_x_position;
      w_wr_data.width = lk_block_width;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_retire_pulse <= 1'b0;
      r_retire_lane  <= '0;
    end else begin
      r_retire_pulse <= (r_state == S_UPDATE) && w_cur.valid && w_off_screen;
      r_retire_lane  <= ((r_state == S_UPDATE) && w_cur.valid && w_off_screen) ? w_cur.lane : '0;
    end
  end

  assign busy          = (r_state == S_UPDATE);
  assign retire_pulse  = r_retire_pulse;
  assign retire_lane   = r_retire_lane;
  assign overrun_count = r_overrun;
  assign rd_valid      = w_rd.valid;
  assign rd_lane       = w_rd.lane;
  assign rd_y          = w_rd.y;
  assign rd_x          = w_rd.x;
  assign rd_width      = w_rd.width;
endmodule

// File: tb/tb_note_slot_scheduler.sv
// Self-checking bench for note_slot_scheduler: directed scenarios plus random
// traffic compared every cycle against a behavioural pool model.
module tb_note_slot_scheduler;
  localparam int NS    = 8;
  localparam int SPEED = 2;
  localparam int YB    = 479;

  logic       Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0, spawn_valid = 1'b0;
  logic [2:0] spawn_lane = '0, lk_block_position, rd_lane, retire_lane;
  logic       spawn_ready, rd_valid, busy, retire_pulse;
  logic [9:0] lk_y_position, lk_x_position, lk_block_width, rd_y, rd_x, rd_width;
  logic [2:0] rd_slot = '0;
  logic [7:0] overrun_count;

  int total = 0, bad = 0;

  always #5 Clk = ~Clk;

  function automatic logic [9:0] stub_x(input logic [2:0] l, input logic [9:0] y);
    return 10'(163 + 77 * int'(l[1:0]) + int'(y >> 2));
  endfunction
  function automatic logic [9:0] stub_w(input logic [9:0] y);
    return 10'(40 + int'(y >> 3));
  endfunction

  assign lk_x_position  = stub_x(lk_block_position, lk_y_position);
  assign lk_block_width = stub_w(lk_y_position);

  note_slot_scheduler #(.NUM_SLOTS(NS), .SPEED(SPEED), .Y_SPAWN(10'd0), .Y_BOTTOM(10'd479)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .spawn_valid(spawn_valid),
    .spawn_lane(spawn_lane), .spawn_ready(spawn_ready), .lk_block_position(lk_block_position),
    .lk_y_position(lk_y_position), .lk_x_position(lk_x_position), .lk_block_width(lk_block_width),
    .rd_slot(rd_slot), .rd_valid(rd_valid), .rd_lane(rd_lane), .rd_y(rd_y), .rd_x(rd_x),
    .rd_width(rd_width), .busy(busy), .retire_pulse(retire_pulse), .retire_lane(retire_lane),
    .overrun_count(overrun_count)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the pool, stepped on each rising edge.
  bit       mv [NS];
  bit [2:0] ml [NS];
  int       my [NS], mx [NS], mw [NS];
  bit       m_live = 0, m_pass = 0, m_pend = 0, m_rp = 0, m_rv = 0;
  int       m_pos = 0, m_ovr = 0, m_rlane = 0, m_rl = 0, m_ry = 0, m_rx = 0, m_rw = 0;
  int       m_f, m_ny;

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NS; i++) begin mv[i] = 0; ml[i] = 0; my[i] = 0; mx[i] = 0; mw[i] = 0; end
      m_pass = 0; m_pend = 0; m_ovr = 0; m_pos = 0; m_rp = 0; m_rlane = 0;
      m_rv = 0; m_rl = 0; m_ry = 0; m_rx = 0; m_rw = 0;
      m_live = 1;
    end else begin
      m_rv = mv[rd_slot]; m_rl = ml[rd_slot]; m_ry = my[rd_slot]; m_rx = mx[rd_slot]; m_rw = mw[rd_slot];
      m_rp = 0; m_rlane = 0;
      if (!m_pass) begin
        m_f = -1;
        for (int i = 0; i < NS; i++) if (!mv[i] && m_f < 0) m_f = i;
        if (spawn_valid && m_f >= 0) begin
          mv[m_f] = 1; ml[m_f] = spawn_lane; my[m_f] = 0;
          mx[m_f] = stub_x(spawn_lane, 10'd0); mw[m_f] = stub_w(10'd0);
        end
        if (frame_tick || m_pend) begin
          if (frame_tick && m_pend && m_ovr < 255) m_ovr++;
          m_pend = 0; m_pass = 1; m_pos = 0;
        end
      end else begin
        if (frame_tick) begin
          if (m_pend) begin if (m_ovr < 255) m_ovr++; end
          else m_pend = 1;
        end
        if (mv[m_pos]) begin
          m_ny = my[m_pos] + SPEED;
          if (m_ny > YB) begin
            mv[m_pos] = 0; m_rp = 1; m_rlane = ml[m_pos];
          end else begin
            my[m_pos] = m_ny;
            mx[m_pos] = stub_x(ml[m_pos], 10'(m_ny));
            mw[m_pos] = stub_w(10'(m_ny));
          end
        end
        if (m_pos == NS - 1) m_pass = 0;
        else m_pos++;
      end
    end
  end

  function automatic bit m_anyfree();
    for (int i = 0; i < NS; i++) if (!mv[i]) return 1;
    return 0;
  endfunction

  always @(negedge Clk) begin
    if (!Reset && m_live) begin
      check("busy", int'(busy), int'(m_pass));
      check("spawn_ready", int'(spawn_ready), int'(!m_pass && m_anyfree()));
      check("retire_pulse", int'(retire_pulse), int'(m_rp));
      if (m_rp) check("retire_lane", int'(retire_lane), m_rlane);
      check("overrun_count", int'(overrun_count), m_ovr);
      check("rd_valid", int'(rd_valid), int'(m_rv));
      check("rd_lane", int'(rd_lane), m_rl);
      check("rd_y", int'(rd_y), m_ry);
      check("rd_x", int'(rd_x), m_rx);
      check("rd_width", int'(rd_width), m_rw);
      if (!m_pass) begin
        check("lk_lane_idle", int'(lk_block_position), int'(spawn_lane));
        check("lk_y_idle", int'(lk_y_position), 0);
      end else if (mv[m_pos]) begin
        check("lk_lane_upd", int'(lk_block_position), int'(ml[m_pos]));
        check("lk_y_upd", int'(lk_y_position), (my[m_pos] + SPEED) & 10'h3FF);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0;
    step();
    Reset = 1'b0;
  endtask

  task automatic tick_pass();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (NS + 2) step();
  endtask

  int  cnt, got, gl;
  bit  hist [60];

  initial begin
    // 1: single spawn, geometry captured from lookup at the spawn row
    do_reset();
    check("reset_overrun", int'(overrun_count), 0);
    check("reset_busy", int'(busy), 0);
    spawn_lane = 3'd2; spawn_valid = 1'b1; rd_slot = 3'd0;
    step();
    spawn_valid = 1'b0;
    step();
    check("t1_valid", int'(rd_valid), 1);
    check("t1_lane", int'(rd_lane), 2);
    check("t1_y", int'(rd_y), 0);
    check("t1_x", int'(rd_x), 317);
    check("t1_w", int'(rd_width), 40);
    check("t1_ready", int'(spawn_ready), 1);

    // 3: one note falls to the bottom and retires on the 240th frame
    do_reset();
    spawn_lane = 3'd1; spawn_valid = 1'b1; rd_slot = 3'd0;
    step();
    spawn_valid = 1'b0;
    repeat (239) tick_pass();
    check("t3_y478", int'(rd_y), 478);
    check("t3_x", int'(rd_x), 359);
    check("t3_w", int'(rd_width), 99);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    got = 0; gl = 0;
    for (int k = 0; k < NS + 4; k++) begin
      if (retire_pulse) begin got++; gl = int'(retire_lane); end
      step();
    end
    check("t3_retire_pulses", got, 1);
    check("t3_retire_lane", gl, 1);
    check("t3_valid_cleared", int'(rd_valid), 0);

    // 2: full pool back-pressures a held request until a slot frees
    do_reset();
    spawn_valid = 1'b1;
    for (int i = 0; i < NS; i++) begin
      spawn_lane = 3'(i % 4);
      step();
    end
    spawn_lane = 3'd6;
    check("t2_full_ready", int'(spawn_ready), 0);
    cnt = 0;
    for (int s = 0; s < NS; s++) begin
      rd_slot = 3'(s);
      step();
      step();
      cnt += int'(rd_valid);
    end
    check("t2_slot_count", cnt, 8);
    repeat (239) tick_pass();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    got = 0;
    for (int k = 0; k < 3 * NS; k++) begin
      if (spawn_ready) begin
        step();
        spawn_valid = 1'b0;
        got = 1;
        break;
      end
      step();
    end
    spawn_valid = 1'b0;
    check("t2_accept_seen", got, 1);
    rd_slot = 3'd0;
    step();
    step();
    check("t2_slot0_valid", int'(rd_valid), 1);
    check("t2_slot0_lane", int'(rd_lane), 6);
    check("t2_slot0_y", int'(rd_y), 0);

    // 4: tick mid-pass queues one back-to-back pass; a further tick is an overrun
    do_reset();
    for (int i = 0; i < 60; i++) begin
      frame_tick = (i == 0 || i == 2 || i == 4);
      step();
      hist[i] = busy;
    end
    frame_tick = 1'b0;
    cnt = 0; got = 0;
    for (int i = 0; i < 60; i++) cnt += int'(hist[i]);
    for (int i = 1; i < 59; i++) if (hist[i-1] && !hist[i] && hist[i+1]) got++;
    check("t4_busy_cycles", cnt, 2 * NS);
    check("t4_gap_count", got, 1);
    check("t4_overrun", int'(overrun_count), 1);

    // 5: spawn and tick in the same idle cycle
    do_reset();
    rd_slot = 3'd0; spawn_lane = 3'd3; spawn_valid = 1'b1; frame_tick = 1'b1;
    step();
    spawn_valid = 1'b0; frame_tick = 1'b0;
    repeat (NS + 2) step();
    check("t5_valid", int'(rd_valid), 1);
    check("t5_y", int'(rd_y), 2);
    check("t5_x", int'(rd_x), 394);
    check("t5_w", int'(rd_width), 40);

    // 6: reset partway through a pass
    do_reset();
    spawn_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin spawn_lane = 3'(i); step(); end
    spawn_valid = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (3) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t6_busy", int'(busy), 0);
    cnt = 0; got = 0;
    for (int s = 0; s < NS; s++) begin
      rd_slot = 3'(s);
      step();
      got += int'(retire_pulse);
      step();
      got += int'(retire_pulse);
      cnt += int'(rd_valid);
    end
    check("t6_valid_count", cnt, 0);
    check("t6_retire_pulses", got, 0);

    // Random traffic, checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      frame_tick  = ($urandom_range(0, 9) == 0);
      spawn_valid = ($urandom_range(0, 3) == 0);
      spawn_lane  = 3'($urandom_range(0, 7));
      rd_slot     = 3'($urandom_range(0, NS - 1));
      Reset       = ($urandom_range(0, 2999) == 0);
      step();
    end
    Reset = 1'b0; frame_tick = 1'b0; spawn_valid = 1'b0;
    repeat (NS + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
